// File: rtl/muldiv_pkg.sv
// Shared instruction definitions for the multiply/divide unit: MIPS funct codes
// and small helpers used when decoding a request.
package muldiv_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    function automatic logic funct_valid(input logic [5:0] f);
        logic ok;
        case (f)
            FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO,
            FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: ok = 1'b1;
            default:                                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Magnitude of a 32-bit operand; 0x80000000 maps to itself as an unsigned value.
    function automatic logic [31:0] mag(input logic [31:0] x, input logic is_signed);
        return (is_signed && x[31]) ? (32'd0 - x) : x;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add for multiply,
// restoring subtract-and-shift for divide, through a single 33-bit adder.
module muldiv_step (
    input  logic        is_div,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    input  logic [31:0] op,
    output logic [31:0] hi_nxt,
    output logic [31:0] lo_nxt
);

    logic [32:0] a;
    logic [32:0] b;
    logic [32:0] sum;

    always_comb begin
        a      = is_div ? {hi, lo[31]} : {1'b0, hi};
        b      = is_div ? ~{1'b0, op} : {1'b0, op};
        sum    = a + b + {32'd0, is_div};
        hi_nxt = hi;
        lo_nxt = lo;
        if (is_div) begin
            // sum[32] set means the trial subtraction went negative: restore
            hi_nxt = sum[32] ? a[31:0] : sum[31:0];
            lo_nxt = {lo[30:0], ~sum[32]};
        end else if (lo[0]) begin
            hi_nxt = sum[32:1];
            lo_nxt = {sum[0], lo[31:1]};
        end else begin
            hi_nxt = {1'b0, hi[31:1]};
            lo_nxt = {hi[0], lo[31:1]};
        end
    end

endmodule

// File: rtl/muldiv.sv
// Iterative MIPS HI/LO multiply/divide unit with MTHI/MTLO/MFHI/MFLO access.
//   state  | meaning
//   S_IDLE | accepting requests; MT*/MF* complete here in one cycle
//   S_MUL  | 32 shift-add iterations on magnitudes
//   S_DIV  | 32 restoring-divide iterations on magnitudes
//   S_FIX  | sign correction; HI/LO final at the edge leaving this state
module muldiv
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [5:0]  funct,
    input  logic [31:0] rrs,
    input  logic [31:0] rrt,
    output logic        busy,
    output logic [31:0] rslt,
    output logic        rslt_vld
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        signed_op;

    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] op;
    logic [4:0]  cnt;
    logic        neg_q;
    logic        neg_r;
    logic        op_mul;

    logic [31:0] step_hi;
    logic [31:0] step_lo;

    assign signed_op = ~funct[0];

    muldiv_step u_step (
        .is_div (state == S_DIV),
        .hi     (hi),
        .lo     (lo),
        .op     (op),
        .hi_nxt (step_hi),
        .lo_nxt (step_lo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (req && funct_valid(funct)) begin
                    accept = 1'b1;
                    if (funct == FUNCT_MULT || funct == FUNCT_MULTU) begin
                        state_nxt = S_MUL;
                    end else if (funct == FUNCT_DIV || funct == FUNCT_DIVU) begin
                        state_nxt = S_DIV;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (cnt == 5'd31) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi       <= 32'd0;
            lo       <= 32'd0;
            op       <= 32'd0;
            cnt      <= 5'd0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            op_mul   <= 1'b0;
            rslt     <= 32'd0;
            rslt_vld <= 1'b0;
        end else begin
            rslt_vld <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (funct)
                            FUNCT_MTHI: hi <= rrs;
                            FUNCT_MTLO: lo <= rrs;
                            FUNCT_MFHI: begin
                                rslt     <= hi;
                                rslt_vld <= 1'b1;
                            end
                            FUNCT_MFLO: begin
                                rslt     <= lo;
                                rslt_vld <= 1'b1;
                            end
                            FUNCT_MULT, FUNCT_MULTU: begin
                                hi     <= 32'd0;
                                lo     <= mag(rrt, signed_op);
                                op     <= mag(rrs, signed_op);
                                neg_q  <= signed_op & (rrs[31] ^ rrt[31]);
                                neg_r  <= 1'b0;
                                op_mul <= 1'b1;
                                cnt    <= 5'd0;
                            end
                            FUNCT_DIV, FUNCT_DIVU: begin
                                hi     <= 32'd0;
                                lo     <= mag(rrs, signed_op);
                                op     <= mag(rrt, signed_op);
                                // a zero divisor leaves quotient all-ones and the
                                // remainder equal to the dividend once re-signed
                                neg_q  <= signed_op & (rrs[31] ^ rrt[31]) & (rrt != 32'd0);
                                neg_r  <= signed_op & rrs[31];
                                op_mul <= 1'b0;
                                cnt    <= 5'd0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL, S_DIV: begin
                    hi  <= step_hi;
                    lo  <= step_lo;
                    cnt <= cnt + 5'd1;
                end
                S_FIX: begin
                    if (op_mul) begin
                        if (neg_q) begin
                            {hi, lo} <= 64'd0 - {hi, lo};
                        end
                    end else begin
                        if (neg_q) begin
                            lo <= 32'd0 - lo;
                        end
                        if (neg_r) begin
                            hi <= 32'd0 - hi;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv: directed vectors, protocol scenarios and
// randomized ops checked against a plain-arithmetic HI/LO model.
module tb_muldiv;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [5:0]  funct;
    logic [31:0] rrs;
    logic [31:0] rrt;
    logic        busy;
    logic [31:0] rslt;
    logic        rslt_vld;

    int tests_run    = 0;
    int tests_failed = 0;

    muldiv dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .funct    (funct),
        .rrs      (rrs),
        .rrt      (rrt),
        .busy     (busy),
        .rslt     (rslt),
        .rslt_vld (rslt_vld)
    );

    always #5 clk = ~clk;

    // Architectural result {HI, LO} of one operation from the instruction rules.
    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] cur);
        int     sa;
        int     sb;
        longint sp;
        sa = a;
        sb = b;
        case (f)
            F_MULTU: return {32'd0, a} * {32'd0, b};
            F_MULT: begin
                sp = longint'(sa) * longint'(sb);
                return sp;
            end
            F_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
            F_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                return {sa % sb, sa / sb};
            end
            F_MTHI:  return {a, cur[31:0]};
            F_MTLO:  return {cur[63:32], a};
            default: return cur;
        endcase
    endfunction

    // Hold a request until the first edge at which the unit is idle.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         output int edges);
        logic was_idle;
        edges = 0;
        req   = 1'b1;
        funct = f;
        rrs   = a;
        rrt   = b;
        do begin
            @(negedge clk);
            was_idle = !busy;
            @(posedge clk);
            #1;
            edges++;
        end while (!was_idle && edges < 200);
        req = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic read_reg(input logic [5:0] f, output logic [31:0] val,
                            output logic v_now, output logic v_next);
        int e;
        issue(f, $urandom, $urandom, e);
        val   = rslt;
        v_now = rslt_vld;
        @(posedge clk);
        #1;
        v_next = rslt_vld;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic        p0;
        logic        p1;
        rst   = 1'b1;
        req   = 1'b0;
        funct = 6'd0;
        rrs   = 32'd0;
        rrt   = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0 || rslt_vld !== 1'b0 || rslt !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: busy=%b vld=%b rslt=%h, expected 0 0 00000000", busy, rslt_vld, rslt);
        end
        rst = 1'b0;
        read_reg(F_MFHI, v, p0, p1);
        tests_run++;
        if (v !== 32'd0 || p0 !== 1'b1 || p1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_hi: rslt=%h vld=%b,%b, expected 00000000 vld=1,0", v, p0, p1);
        end
        read_reg(F_MFLO, v, p0, p1);
        tests_run++;
        if (v !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_lo: rslt=%h, expected 00000000", v);
        end
    endtask

    task automatic test_directed();
        logic [5:0]  vf  [7];
        logic [31:0] va  [7];
        logic [31:0] vb  [7];
        logic [31:0] vhi [7];
        logic [31:0] vlo [7];
        logic [31:0] v;
        logic        p0;
        logic        p1;
        int          e;
        int          cyc;
        vf  = '{F_MULTU, F_MULT, F_DIV, F_DIVU, F_DIV, F_DIV, F_MULT};
        va  = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'h80000000, 32'hFFFFFFFB, 32'h80000000};
        vb  = '{32'hFFFFFFFF, 32'd7, 32'd2, 32'd0, 32'hFFFFFFFF, 32'd0, 32'h80000000};
        vhi = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000064, 32'd0, 32'hFFFFFFFB, 32'h40000000};
        vlo = '{32'h00000001, 32'hFFFFFFEB, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'd0};
        for (int i = 0; i < 7; i++) begin
            issue(vf[i], va[i], vb[i], e);
            wait_idle(cyc);
            tests_run++;
            if (cyc != 33) begin
                tests_failed++;
                $display("FAIL directed_busy[%0d]: busy cycles=%0d, expected 33", i, cyc);
            end
            read_reg(F_MFHI, v, p0, p1);
            tests_run++;
            if (v !== vhi[i]) begin
                tests_failed++;
                $display("FAIL directed_hi[%0d]: HI=%h, expected %h", i, v, vhi[i]);
            end
            read_reg(F_MFLO, v, p0, p1);
            tests_run++;
            if (v !== vlo[i]) begin
                tests_failed++;
                $display("FAIL directed_lo[%0d]: LO=%h, expected %h", i, v, vlo[i]);
            end
        end
    endtask

    task automatic test_mt_mf();
        logic [31:0] v;
        logic        p0;
        logic        p1;
        int          e;
        issue(F_MTHI, 32'h00001234, 32'd0, e);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL mthi_busy: busy=%b, expected 0", busy);
        end
        issue(F_MTLO, 32'hCAFEF00D, 32'd0, e);
        issue(F_MFHI, 32'd0, 32'd0, e);
        tests_run++;
        if (rslt !== 32'h00001234 || rslt_vld !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL mfhi_read: rslt=%h vld=%b busy=%b, expected 00001234 1 0", rslt, rslt_vld, busy);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (rslt_vld !== 1'b0 || rslt !== 32'h00001234) begin
            tests_failed++;
            $display("FAIL mf_hold: rslt=%h vld=%b, expected 00001234 0", rslt, rslt_vld);
        end
        read_reg(F_MFLO, v, p0, p1);
        tests_run++;
        if (v !== 32'hCAFEF00D || p0 !== 1'b1 || p1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL mtlo_read: rslt=%h vld=%b,%b, expected cafef00d 1,0", v, p0, p1);
        end
    endtask

    task automatic test_mf_pending();
        int          e;
        int          busy_low_at;
        int          vld_at;
        int          pulses;
        int          vld_busy;
        logic [31:0] got;
        issue(F_DIVU, 32'd9, 32'd2, e);
        req         = 1'b1;
        funct       = F_MFLO;
        rrs         = 32'd0;
        rrt         = 32'd0;
        busy_low_at = -1;
        vld_at      = -1;
        pulses      = 0;
        vld_busy    = 0;
        got         = 32'd0;
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk);
            #1;
            if (rslt_vld) begin
                pulses++;
                if (busy) vld_busy++;
                if (vld_at < 0) begin
                    vld_at = c;
                    got    = rslt;
                end
                req = 1'b0;
            end
            if (!busy && busy_low_at < 0) busy_low_at = c;
        end
        req = 1'b0;
        tests_run++;
        if (busy_low_at != 33 || vld_busy != 0) begin
            tests_failed++;
            $display("FAIL pend_busy: busy fell after %0d cycles, vld while busy=%0d, expected 33 and 0", busy_low_at, vld_busy);
        end
        tests_run++;
        if (vld_at != 34 || pulses != 1) begin
            tests_failed++;
            $display("FAIL pend_accept: vld at cycle %0d pulses=%0d, expected 34 and 1", vld_at, pulses);
        end
        tests_run++;
        if (got !== 32'd4) begin
            tests_failed++;
            $display("FAIL pend_data: rslt=%h, expected 00000004", got);
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] v;
        logic        p0;
        logic        p1;
        int          e;
        issue(F_MULT, 32'd12345, 32'hFFFFE57B, e);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL midop_busy: busy=%b, expected 1", busy);
        end
        rst   = 1'b1;
        req   = 1'b1;
        funct = F_MTHI;
        rrs   = 32'h0000DEAD;
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || rslt_vld !== 1'b0 || rslt !== 32'd0) begin
            tests_failed++;
            $display("FAIL midop_reset: busy=%b vld=%b rslt=%h, expected 0 0 00000000", busy, rslt_vld, rslt);
        end
        read_reg(F_MFLO, v, p0, p1);
        tests_run++;
        if (v !== 32'd0) begin
            tests_failed++;
            $display("FAIL midop_lo: LO=%h, expected 00000000", v);
        end
        read_reg(F_MFHI, v, p0, p1);
        tests_run++;
        if (v !== 32'd0) begin
            tests_failed++;
            $display("FAIL midop_hi: HI=%h, expected 00000000 (reset beats MTHI)", v);
        end
    endtask

    task automatic test_invalid_funct();
        logic [5:0]  bad [4];
        logic [31:0] v;
        logic        p0;
        logic        p1;
        int          e;
        int          bad_cycles;
        bad = '{6'h00, 6'h14, 6'h1C, 6'h3F};
        issue(F_MTHI, 32'hA5A5A5A5, 32'd0, e);
        issue(F_MTLO, 32'h5A5A5A5A, 32'd0, e);
        bad_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            req   = 1'b1;
            funct = bad[i];
            rrs   = $urandom;
            rrt   = $urandom;
            repeat (3) begin
                @(posedge clk);
                #1;
                if (busy !== 1'b0 || rslt_vld !== 1'b0) bad_cycles++;
            end
        end
        req = 1'b0;
        tests_run++;
        if (bad_cycles != 0) begin
            tests_failed++;
            $display("FAIL invalid_quiet: %0d cycles with busy/vld set, expected 0", bad_cycles);
        end
        read_reg(F_MFHI, v, p0, p1);
        tests_run++;
        if (v !== 32'hA5A5A5A5) begin
            tests_failed++;
            $display("FAIL invalid_hi: HI=%h, expected a5a5a5a5", v);
        end
        read_reg(F_MFLO, v, p0, p1);
        tests_run++;
        if (v !== 32'h5A5A5A5A) begin
            tests_failed++;
            $display("FAIL invalid_lo: LO=%h, expected 5a5a5a5a", v);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp;
        logic [31:0] v;
        logic        p0;
        logic        p1;
        int          e;
        int          cyc;
        issue(F_MULTU, 32'd1000, 32'd3000, e);
        wait_idle(cyc);
        issue(F_DIV, 32'hFFFFFF9C, 32'd7, e);
        tests_run++;
        if (e != 1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_accept: accepted after %0d edges busy=%b, expected 1 and 1", e, busy);
        end
        wait_idle(cyc);
        tests_run++;
        if (cyc != 33) begin
            tests_failed++;
            $display("FAIL b2b_busy: busy cycles=%0d, expected 33", cyc);
        end
        exp = model(F_DIV, 32'hFFFFFF9C, 32'd7, 64'd0);
        read_reg(F_MFHI, v, p0, p1);
        tests_run++;
        if (v !== exp[63:32]) begin
            tests_failed++;
            $display("FAIL b2b_hi: HI=%h, expected %h", v, exp[63:32]);
        end
        read_reg(F_MFLO, v, p0, p1);
        tests_run++;
        if (v !== exp[31:0]) begin
            tests_failed++;
            $display("FAIL b2b_lo: LO=%h, expected %h", v, exp[31:0]);
        end
    endtask

    task automatic test_random();
        logic [5:0]  kinds [6];
        logic [63:0] hilo;
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] v;
        logic        p0;
        logic        p1;
        int          e;
        int          cyc;
        kinds = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO};
        issue(F_MTHI, 32'd0, 32'd0, e);
        issue(F_MTLO, 32'd0, 32'd0, e);
        hilo = 64'd0;
        for (int n = 0; n < 40; n++) begin
            f = kinds[$urandom_range(0, 5)];
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFFFFFF;
                2:       b = $urandom_range(1, 15);
                3:       b = 32'h80000000;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) a = 32'h80000000;
            issue(f, a, b, e);
            hilo = model(f, a, b, hilo);
            if (f == F_MTHI || f == F_MTLO) begin
                tests_run++;
                if (busy !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL rand_mt_busy[%0d]: busy=%b, expected 0", n, busy);
                end
            end else begin
                wait_idle(cyc);
                tests_run++;
                if (cyc != 33) begin
                    tests_failed++;
                    $display("FAIL rand_busy[%0d]: funct=%h busy cycles=%0d, expected 33", n, f, cyc);
                end
            end
            read_reg(F_MFHI, v, p0, p1);
            tests_run++;
            if (v !== hilo[63:32] || p0 !== 1'b1 || p1 !== 1'b0) begin
                tests_failed++;
                $display("FAIL rand_hi[%0d]: funct=%h a=%h b=%h HI=%h vld=%b,%b, expected %h vld=1,0", n, f, a, b, v, p0, p1, hilo[63:32]);
            end
            read_reg(F_MFLO, v, p0, p1);
            tests_run++;
            if (v !== hilo[31:0]) begin
                tests_failed++;
                $display("FAIL rand_lo[%0d]: funct=%h a=%h b=%h LO=%h, expected %h", n, f, a, b, v, hilo[31:0]);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_mt_mf();
        test_mf_pending();
        test_reset_midop();
        test_invalid_funct();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
